// File: rtl/mem_stage_pkg.sv
// Shared definitions for the RV32I memory stage: load/store width codes, FSM states
// and the alignment rule used to reject illegal accesses.
package mem_stage_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_BUSY = 2'd1,
    MS_DONE = 2'd2
  } ms_state_e;

  // Unsupported width codes are reported through the same misalign path.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    case (funct3)
      F3_B, F3_BU: mis = 1'b0;
      F3_H, F3_HU: mis = addr_lo[0];
      F3_W:        mis = |addr_lo;
      default:     mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Selects the addressed byte/halfword lane of a read word and sign- or zero-extends it.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_value
);

  logic [31:0] w_shifted;

  always_comb begin
    w_shifted = i_rdata >> {i_lane, 3'b000};
    case (i_funct3)
      F3_B:    o_value = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_BU:   o_value = {24'd0, w_shifted[7:0]};
      F3_H:    o_value = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_HU:   o_value = {16'd0, w_shifted[15:0]};
      default: o_value = w_shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: req/ack data bus master, pipeline stall and load alignment.
// Optional MEM_TIMEOUT_EN adds a BUSY watchdog that aborts after TIMEOUT_CYC cycles.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        VALID_EM,
  input  logic        MemRead_EM,
  input  logic        MemWrite_EM,
  input  logic [2:0]  FUNCT3_EM,
  input  logic [31:0] ALU_VAL_EM,
  input  logic [31:0] STORE_VAL_EM,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [31:0] DMEM_ADDR,
  output logic [3:0]  DMEM_BE,
  output logic [31:0] DMEM_WDATA,
  input  logic        DMEM_ACK,
  input  logic [31:0] DMEM_RDATA,
  output logic [31:0] LOAD_VAL_M,
  output logic        STALL_M,
  output logic        MISALIGN_M,
  output logic        BUS_ERR_M
);

  if (TIMEOUT_CYC == 0 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("mem_stage: TIMEOUT_CYC must be in 1..255");
  end

  ms_state_e   r_state;
  logic        r_req, r_we, r_misalign;
  logic [31:0] r_addr, r_wdata, r_load_val;
  logic [3:0]  r_be;
  logic [1:0]  r_lane;
  logic [2:0]  r_funct3;

  logic        w_start, w_misalign;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_load_ext;

  assign w_start    = VALID_EM & (MemRead_EM | MemWrite_EM);
  assign w_misalign = is_misaligned(FUNCT3_EM, ALU_VAL_EM[1:0]);

  // Gated by rst_n so the pipeline never sees a stall while reset is held.
  assign STALL_M = rst_n & ((r_state == MS_BUSY) |
                            ((r_state == MS_IDLE) & w_start & ~w_misalign));

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = STORE_VAL_EM;
    case (FUNCT3_EM[1:0])
      2'b00: begin
        w_be    = 4'b0001 << ALU_VAL_EM[1:0];
        w_wdata = {4{STORE_VAL_EM[7:0]}};
      end
      2'b01: begin
        w_be    = ALU_VAL_EM[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{STORE_VAL_EM[15:0]}};
      end
      default: w_be = 4'b1111;
    endcase
  end

  load_align u_load_align (
    .i_rdata  (DMEM_RDATA),
    .i_lane   (r_lane),
    .i_funct3 (r_funct3),
    .o_value  (w_load_ext)
  );

`ifdef MEM_TIMEOUT_EN
  logic [7:0] r_tmo_cnt;
  logic       r_bus_err;
  assign BUS_ERR_M = r_bus_err;
`else
  assign BUS_ERR_M = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= MS_IDLE;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_lane     <= '0;
      r_funct3   <= '0;
      r_load_val <= '0;
      r_misalign <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      r_tmo_cnt  <= '0;
      r_bus_err  <= 1'b0;
`endif
    end else begin
      r_misalign <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      r_bus_err  <= 1'b0;
`endif
      case (r_state)
        MS_IDLE: begin
          if (w_start) begin
            if (w_misalign) begin
              r_misalign <= 1'b1;
              r_load_val <= '0;
            end else begin
              r_req    <= 1'b1;
              r_we     <= MemWrite_EM;
              r_addr   <= {ALU_VAL_EM[31:2], 2'b00};
              r_be     <= w_be;
              r_wdata  <= w_wdata;
              r_lane   <= ALU_VAL_EM[1:0];
              r_funct3 <= FUNCT3_EM;
              r_state  <= MS_BUSY;
`ifdef MEM_TIMEOUT_EN
              r_tmo_cnt <= '0;
`endif
            end
          end
        end
        MS_BUSY: begin
          if (DMEM_ACK) begin
            r_req <= 1'b0;
            if (!r_we) r_load_val <= w_load_ext;
            r_state <= MS_DONE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (r_tmo_cnt == 8'(TIMEOUT_CYC - 1)) begin
            r_req      <= 1'b0;
            r_load_val <= '0;
            r_bus_err  <= 1'b1;
            r_state    <= MS_DONE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
          end
`endif
        end
        MS_DONE: r_state <= MS_IDLE;
        default: r_state <= MS_IDLE;
      endcase
    end
  end

  assign DMEM_REQ   = r_req;
  assign DMEM_WE    = r_we;
  assign DMEM_ADDR  = r_addr;
  assign DMEM_BE    = r_be;
  assign DMEM_WDATA = r_wdata;
  assign LOAD_VAL_M = r_load_val;
  assign MISALIGN_M = r_misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus queues expected bus requests, a bus responder
// checks them, acks with random latency and updates the expected load value.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        VALID_EM = 1'b0, MemRead_EM = 1'b0, MemWrite_EM = 1'b0;
  logic [2:0]  FUNCT3_EM = 3'd0;
  logic [31:0] ALU_VAL_EM = '0, STORE_VAL_EM = '0;
  logic        DMEM_REQ, DMEM_WE;
  logic [31:0] DMEM_ADDR, DMEM_WDATA;
  logic [3:0]  DMEM_BE;
  logic        DMEM_ACK = 1'b0;
  logic [31:0] DMEM_RDATA = '0;
  logic [31:0] LOAD_VAL_M;
  logic        STALL_M, MISALIGN_M, BUS_ERR_M;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYC(255)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .VALID_EM     (VALID_EM),
    .MemRead_EM   (MemRead_EM),
    .MemWrite_EM  (MemWrite_EM),
    .FUNCT3_EM    (FUNCT3_EM),
    .ALU_VAL_EM   (ALU_VAL_EM),
    .STORE_VAL_EM (STORE_VAL_EM),
    .DMEM_REQ     (DMEM_REQ),
    .DMEM_WE      (DMEM_WE),
    .DMEM_ADDR    (DMEM_ADDR),
    .DMEM_BE      (DMEM_BE),
    .DMEM_WDATA   (DMEM_WDATA),
    .DMEM_ACK     (DMEM_ACK),
    .DMEM_RDATA   (DMEM_RDATA),
    .LOAD_VAL_M   (LOAD_VAL_M),
    .STALL_M      (STALL_M),
    .MISALIGN_M   (MISALIGN_M),
    .BUS_ERR_M    (BUS_ERR_M)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [1:0]  lane;
  } req_t;

  req_t        req_q[$];
  int          n_cmp = 0, n_err = 0;
  logic [31:0] exp_load = '0;
  int          last_delay = 0, forced_delay = -1;
  bit          no_ack = 0, stray_req = 0, force_rd = 0;
  logic [31:0] forced_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: access size in bytes and the rules derived from it.
  function automatic int size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit model_mis(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    return (a % size_of(f3)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int s = size_of(f3);
    return 4'(((1 << s) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    int s = size_of(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % s) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [1:0] lane,
                                             input logic [2:0] f3);
    logic [31:0] v, mask;
    int s = size_of(f3);
    v = rd >> (8 * lane);
    if (s == 4) return v;
    mask = (s == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
    v = v & mask;
    if (!f3[2] && v[8*s-1]) v = v | ~mask;
    return v;
  endfunction

  // Bus responder and request monitor.
  initial begin : responder
    req_t cur;
    int   dly = 0;
    bit   seen = 0, drop_chk = 0;
    forever begin
      @(negedge clk);
      DMEM_ACK = 1'b0;
      if (drop_chk) begin
        chk("req_drop_after_ack", {31'd0, DMEM_REQ}, 32'd0);
        drop_chk = 0;
      end
      if (!rst_n) begin
        seen = 0;
        continue;
      end
      if (!seen && DMEM_REQ) begin
        if (req_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_req: got request addr %h, expected none", DMEM_ADDR);
        end else begin
          cur = req_q.pop_front();
          chk("req_we", {31'd0, DMEM_WE}, {31'd0, cur.we});
          chk("req_addr", DMEM_ADDR, cur.addr);
          chk("req_be", {28'd0, DMEM_BE}, {28'd0, cur.be});
          chk("req_wdata", DMEM_WDATA, cur.wdata);
          seen = 1;
          dly = (forced_delay >= 0) ? forced_delay : int'($urandom_range(0, 3));
          last_delay = dly;
        end
      end else if (seen) begin
        chk("hold_addr", DMEM_ADDR, cur.addr);
        chk("hold_ctl", {26'd0, DMEM_REQ, DMEM_WE, DMEM_BE}, {26'd0, 1'b1, cur.we, cur.be});
      end else if (stray_req || $urandom_range(0, 7) == 0) begin
        DMEM_ACK   = 1'b1;
        DMEM_RDATA = $urandom;
        stray_req  = 0;
      end
      if (seen && !no_ack) begin
        if (dly == 0) begin
          DMEM_ACK   = 1'b1;
          DMEM_RDATA = force_rd ? forced_rdata : $urandom;
          if (!cur.we) exp_load = model_load(DMEM_RDATA, cur.lane, cur.f3);
          seen = 0;
          drop_chk = 1;
        end else begin
          dly--;
        end
      end
    end
  end

  // Issue one EX/MEM slot, hold it while stalled, then check the stage's results.
  task automatic do_op(input bit v, input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    bit mem = v && (rd || wr);
    bit mis = mem && model_mis(f3, a);
    bit go  = mem && !mis;
    int st  = 0;
    bit released = 0;
    if (go) req_q.push_back('{we: wr, addr: {a[31:2], 2'b00}, be: model_be(f3, a),
                              wdata: model_wdata(f3, d), f3: f3, lane: a[1:0]});
    VALID_EM = v; MemRead_EM = rd; MemWrite_EM = wr;
    FUNCT3_EM = f3; ALU_VAL_EM = a; STORE_VAL_EM = d;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!STALL_M) begin
        released = 1;
        break;
      end
      st++;
      @(posedge clk); #1;
    end
    if (!released) begin
      n_cmp++;
      n_err++;
      $display("FAIL stall_timeout: stall still high after %0d cycles, expected release", st);
    end
    if (mis) exp_load = '0;
    chk("stall_cycles", st, go ? 2 + last_delay : 0);
    @(posedge clk); #1;
    VALID_EM = 1'b0;
    @(negedge clk);
    chk("misalign_pulse", {31'd0, MISALIGN_M}, {31'd0, mis});
    chk("load_val", LOAD_VAL_M, exp_load);
    chk("bus_err", {31'd0, BUS_ERR_M}, 32'd0);
    chk("no_stall_idle", {31'd0, STALL_M}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("misalign_clear", {31'd0, MISALIGN_M}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    VALID_EM = 1'b1; MemRead_EM = 1'b1; FUNCT3_EM = 3'b010; ALU_VAL_EM = 32'h100;
    #12;
    chk("rst_stall", {31'd0, STALL_M}, 32'd0);
    chk("rst_ctl", {26'd0, DMEM_REQ, DMEM_WE, DMEM_BE}, 32'd0);
    chk("rst_addr", DMEM_ADDR, 32'd0);
    chk("rst_wdata", DMEM_WDATA, 32'd0);
    chk("rst_load", LOAD_VAL_M, 32'd0);
    chk("rst_flags", {30'd0, MISALIGN_M, BUS_ERR_M}, 32'd0);
    VALID_EM = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // LW aligned, ack one cycle after the request becomes visible.
    forced_delay = 1; force_rd = 1; forced_rdata = 32'hDEAD_BEEF;
    do_op(1, 1, 0, 3'b010, 32'h100, 32'h0);
    chk("lw_value", LOAD_VAL_M, 32'hDEAD_BEEF);
    forced_delay = -1;
    forced_rdata = 32'h80FF_FF7F;
    do_op(1, 1, 0, 3'b000, 32'h103, 32'h0);
    chk("lb_lane3", LOAD_VAL_M, 32'hFFFF_FF80);
    do_op(1, 1, 0, 3'b100, 32'h103, 32'h0);
    chk("lbu_lane3", LOAD_VAL_M, 32'h0000_0080);
    force_rd = 0;
    do_op(1, 0, 1, 3'b001, 32'h202, 32'h1234_ABCD);
    do_op(1, 1, 0, 3'b010, 32'h101, 32'h0);
    chk("lw_misaligned_zero", LOAD_VAL_M, 32'd0);
    do_op(1, 1, 1, 3'b000, 32'h7, 32'hA5);

    // Reset while a transaction is outstanding.
    no_ack = 1;
    req_q.push_back('{we: 1'b0, addr: 32'h40, be: 4'hF, wdata: 32'h0, f3: 3'b010, lane: 2'd0});
    VALID_EM = 1'b1; MemRead_EM = 1'b1; MemWrite_EM = 1'b0;
    FUNCT3_EM = 3'b010; ALU_VAL_EM = 32'h40; STORE_VAL_EM = 32'h0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_busy_req_drop", {31'd0, DMEM_REQ}, 32'd0);
    chk("rst_busy_stall", {31'd0, STALL_M}, 32'd0);
    exp_load = '0;
    VALID_EM = 1'b0;
    no_ack = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    stray_req = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_load", LOAD_VAL_M, 32'd0);
    chk("post_rst_req", {31'd0, DMEM_REQ}, 32'd0);
    do_op(1, 1, 0, 3'b101, 32'h302, 32'h0);

    for (int n = 0; n < 300; n++) begin
      do_op($urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom), 3'($urandom),
            $urandom, $urandom);
    end

    chk("req_q_empty", req_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
